// File: rtl/dnn_result_argmax_if.sv
// Bundles the request, engine-control and result signals of the argmax controller.
// The slave modport is the controller's view; the master modport is the host/engine side.
interface dnn_result_argmax_if #(
    parameter int DATA_WIDTH = 2,
    parameter int IDX_WIDTH  = 4
);
    logic                  req;
    logic                  busy;
    logic                  eng_reset;
    logic                  eng_start;
    logic                  eng_done;
    logic [IDX_WIDTH-1:0]  out_idx;
    logic [DATA_WIDTH-1:0] score;
    logic                  digit_valid;
    logic [IDX_WIDTH-1:0]  digit;
    logic [DATA_WIDTH-1:0] max_score;
    logic                  tie;
    logic                  timeout;

    modport master (
        output req, eng_done, score,
        input  busy, eng_reset, eng_start, out_idx,
        input  digit_valid, digit, max_score, tie, timeout
    );

    modport slave (
        input  req, eng_done, score,
        output busy, eng_reset, eng_start, out_idx,
        output digit_valid, digit, max_score, tie, timeout
    );
endinterface

// File: rtl/dnn_result_argmax.sv
// Host-side controller: clears and starts the inference engine, waits for done, sweeps the
// class scores one per cycle and reports the signed argmax with a one-cycle valid pulse.
module dnn_result_argmax #(
    parameter int DATA_WIDTH     = 2,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                rst,
    dnn_result_argmax_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_SCAN   = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]     TIMEOUT_VAL   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX      = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] DIGIT_TIMEOUT = {IDX_WIDTH{1'b1}};

    state_t                        state_r;
    state_t                        state_s;
    logic [CNT_W-1:0]              wait_cnt_r;
    logic [CNT_W-1:0]              wait_cnt_inc_s;
    logic                          timeout_hit_s;

    logic                          busy_r, busy_s;
    logic                          eng_reset_r, eng_reset_s;
    logic                          eng_start_r, eng_start_s;
    logic                          digit_valid_r, digit_valid_s;
    logic [IDX_WIDTH-1:0]          out_idx_r, out_idx_s;

    logic signed [DATA_WIDTH-1:0]  score_s;
    logic signed [DATA_WIDTH-1:0]  run_max_r, cand_max_s;
    logic [IDX_WIDTH-1:0]          run_arg_r, cand_arg_s;
    logic                          run_tie_r, cand_tie_s;

    logic [IDX_WIDTH-1:0]          digit_r;
    logic signed [DATA_WIDTH-1:0]  max_score_r;
    logic                          tie_r;
    logic                          timeout_r;

    assign score_s        = $signed(bus.score);
    assign wait_cnt_inc_s = wait_cnt_r + CNT_W'(1);
    assign timeout_hit_s  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc_s == TIMEOUT_VAL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; done has priority over the timeout in the same WAIT cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.req) begin
                    state_s = S_CLR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLR:   state_s = S_START;
            S_START: state_s = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done) begin
                    state_s = S_SCAN;
                end else if (timeout_hit_s) begin
                    state_s = S_REPORT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_SCAN: begin
                if (out_idx_r == LAST_IDX) begin
                    state_s = S_REPORT;
                end else begin
                    state_s = S_SCAN;
                end
            end
            S_REPORT: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        busy_s        = (state_s != S_IDLE);
        eng_reset_s   = (state_s == S_CLR);
        eng_start_s   = (state_s == S_START);
        digit_valid_s = (state_s == S_REPORT);
        if ((state_r == S_SCAN) && (state_s == S_SCAN)) begin
            out_idx_s = out_idx_r + IDX_WIDTH'(1);
        end else begin
            out_idx_s = {IDX_WIDTH{1'b0}};
        end
    end

    // Control output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r        <= 1'b0;
            eng_reset_r   <= 1'b0;
            eng_start_r   <= 1'b0;
            digit_valid_r <= 1'b0;
            out_idx_r     <= {IDX_WIDTH{1'b0}};
        end else begin
            busy_r        <= busy_s;
            eng_reset_r   <= eng_reset_s;
            eng_start_r   <= eng_start_s;
            digit_valid_r <= digit_valid_s;
            out_idx_r     <= out_idx_s;
        end
    end

    // Running argmax candidate; on equal scores the earlier index is kept
    always_comb begin
        cand_max_s = run_max_r;
        cand_arg_s = run_arg_r;
        cand_tie_s = run_tie_r;
        if (out_idx_r == {IDX_WIDTH{1'b0}}) begin
            cand_max_s = score_s;
            cand_arg_s = {IDX_WIDTH{1'b0}};
            cand_tie_s = 1'b0;
        end else if (score_s > run_max_r) begin
            cand_max_s = score_s;
            cand_arg_s = out_idx_r;
            cand_tie_s = 1'b0;
        end else if (score_s == run_max_r) begin
            cand_tie_s = 1'b1;
        end else begin
            cand_tie_s = run_tie_r;
        end
    end

    // Wait counter, scan accumulators and the result fields
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r  <= {CNT_W{1'b0}};
            run_max_r   <= {DATA_WIDTH{1'b0}};
            run_arg_r   <= {IDX_WIDTH{1'b0}};
            run_tie_r   <= 1'b0;
            digit_r     <= {IDX_WIDTH{1'b0}};
            max_score_r <= {DATA_WIDTH{1'b0}};
            tie_r       <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            if (state_r == S_START) begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == S_WAIT) begin
                wait_cnt_r <= wait_cnt_inc_s;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end

            if (state_r == S_SCAN) begin
                run_max_r <= cand_max_s;
                run_arg_r <= cand_arg_s;
                run_tie_r <= cand_tie_s;
            end else begin
                run_max_r <= run_max_r;
                run_arg_r <= run_arg_r;
                run_tie_r <= run_tie_r;
            end

            if ((state_r == S_SCAN) && (state_s == S_REPORT)) begin
                digit_r     <= cand_arg_s;
                max_score_r <= cand_max_s;
                tie_r       <= cand_tie_s;
                timeout_r   <= 1'b0;
            end else if ((state_r == S_WAIT) && (state_s == S_REPORT)) begin
                digit_r     <= DIGIT_TIMEOUT;
                max_score_r <= {DATA_WIDTH{1'b0}};
                tie_r       <= 1'b0;
                timeout_r   <= 1'b1;
            end else if (state_s == S_CLR) begin
                timeout_r   <= 1'b0;
            end else begin
                timeout_r   <= timeout_r;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.eng_reset   = eng_reset_r;
    assign bus.eng_start   = eng_start_r;
    assign bus.out_idx     = out_idx_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.digit       = digit_r;
    assign bus.max_score   = max_score_r;
    assign bus.tie         = tie_r;
    assign bus.timeout     = timeout_r;

endmodule
